// File: rtl/local_history_table_if.sv
// Lookup/resolve port bundle for the local history table.
// The master drives requests and outcomes; the slave returns history and occupancy.
interface local_history_table_if #(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned HIST_W  = 10,
  parameter int unsigned DEPTH   = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic               LookupValid;
  logic [INDEX_W-1:0] PCindex;
  logic [HIST_W-1:0]  LHTresult;
  logic               LHTvalid;
  logic               ResolveValid;
  logic               BranchTaken;
  logic               Full;
  logic [CntW-1:0]    Outstanding;

  modport master (
    output LookupValid, PCindex, ResolveValid, BranchTaken,
    input  LHTresult, LHTvalid, Full, Outstanding
  );

  modport slave (
    input  LookupValid, PCindex, ResolveValid, BranchTaken,
    output LHTresult, LHTvalid, Full, Outstanding
  );
endinterface

// File: rtl/local_history_table.sv
// Per-PC-index local branch history table with an in-order FIFO that pairs each
// accepted lookup with its later resolution, which shifts the outcome into that history.
module local_history_table #(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned HIST_W  = 10,
  parameter int unsigned DEPTH   = 4
) (
  input logic                  clock,
  input logic                  reset,
  local_history_table_if.slave bus
);
  localparam int unsigned TableSize = 2 ** INDEX_W;
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam int unsigned CntW      = PtrW + 1;

  logic [HIST_W-1:0]  r_table [TableSize];
  logic [INDEX_W-1:0] r_fifo  [DEPTH];
  logic [PtrW-1:0]    r_rd_ptr;
  logic [PtrW-1:0]    r_wr_ptr;
  logic [CntW-1:0]    r_count;
  logic [HIST_W-1:0]  r_result;
  logic               r_valid;

  logic               w_lookup_acc;
  logic               w_resolve_acc;
  logic [INDEX_W-1:0] w_head_idx;
  logic [HIST_W-1:0]  w_shifted;
  logic [HIST_W-1:0]  w_lookup_hist;
  logic [CntW-1:0]    w_count_next;

  // Acceptance uses the count before the edge, so a full FIFO rejects even with a pop.
  assign w_lookup_acc  = bus.LookupValid && (r_count != CntW'(DEPTH));
  assign w_resolve_acc = bus.ResolveValid && (r_count != '0);
  assign w_head_idx    = r_fifo[r_rd_ptr];
  assign w_shifted     = {r_table[w_head_idx][HIST_W-2:0], bus.BranchTaken};

  // Same-edge resolve to the looked-up index forwards the freshly shifted history.
  assign w_lookup_hist = (w_resolve_acc && (w_head_idx == bus.PCindex)) ? w_shifted
                                                                          : r_table[bus.PCindex];

  always_comb begin
    w_count_next = r_count;
    if (w_lookup_acc && !w_resolve_acc) begin
      w_count_next = r_count + CntW'(1);
    end else if (!w_lookup_acc && w_resolve_acc) begin
      w_count_next = r_count - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < TableSize; i++) begin
        r_table[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_lookup_acc;
      r_count <= w_count_next;
      if (w_resolve_acc) begin
        r_table[w_head_idx] <= w_shifted;
        r_rd_ptr            <= r_rd_ptr + PtrW'(1);
      end
      if (w_lookup_acc) begin
        r_result         <= w_lookup_hist;
        r_fifo[r_wr_ptr] <= bus.PCindex;
        r_wr_ptr         <= r_wr_ptr + PtrW'(1);
      end
    end
  end

  assign bus.LHTresult   = r_result;
  assign bus.LHTvalid    = r_valid;
  assign bus.Full        = (r_count == CntW'(DEPTH));
  assign bus.Outstanding = r_count;
endmodule

// File: tb/tb_local_history_table.sv
// Scoreboard bench for local_history_table: directed scenarios plus random traffic,
// checked against a queue/array reference model of the history table.
module tb_local_history_table;
  localparam int unsigned INDEX_W = 10;
  localparam int unsigned HIST_W  = 10;
  localparam int unsigned DEPTH   = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  local_history_table_if #(.INDEX_W(INDEX_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) bus ();

  local_history_table #(.INDEX_W(INDEX_W), .HIST_W(HIST_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: history per index, in-flight index list, expected LHTresult stream.
  logic [HIST_W-1:0] m_hist [2**INDEX_W];
  int                m_inflight [$];
  logic [HIST_W-1:0] exp_q [$];
  logic [HIST_W-1:0] m_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every LHTvalid pulse must match the next expected history.
  always @(negedge clock) begin
    if (bus.LHTvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_LHTvalid", 32'd1, 32'd0);
      end else begin
        check("LHTresult", 32'(bus.LHTresult), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 2**INDEX_W; i++) m_hist[i] = '0;
    m_inflight.delete();
    m_result = '0;
  endtask

  task automatic do_reset(input int n);
    reset                = 1'b1;
    bus.LookupValid      = 1'b0;
    bus.ResolveValid     = 1'b0;
    bus.PCindex          = '0;
    bus.BranchTaken      = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    check("rst_Outstanding", 32'(bus.Outstanding), 32'd0);
    check("rst_Full", 32'(bus.Full), 32'd0);
    check("rst_LHTvalid", 32'(bus.LHTvalid), 32'd0);
    check("rst_LHTresult", 32'(bus.LHTresult), 32'd0);
  endtask

  // One clock of stimulus; model applies the resolve first so a same-edge lookup sees it.
  task automatic cycle(input bit lv, input int idx, input bit rv, input bit bt);
    bit lacc;
    bit racc;
    lacc = lv && (m_inflight.size() < DEPTH);
    racc = rv && (m_inflight.size() > 0);
    bus.LookupValid  = lv;
    bus.PCindex      = lv ? INDEX_W'(idx) : 'x;
    bus.ResolveValid = rv;
    bus.BranchTaken  = rv ? bt : 1'bx;
    if (rv && !racc) $display("note: resolve issued with nothing outstanding at %0t", $time);
    if (racc) begin
      int h;
      h = m_inflight.pop_front();
      m_hist[h] = {m_hist[h][HIST_W-2:0], bt};
    end
    if (lacc) begin
      m_result = m_hist[idx];
      exp_q.push_back(m_result);
      m_inflight.push_back(idx);
    end
    @(posedge clock);
    #1;
    bus.LookupValid  = 1'b0;
    bus.ResolveValid = 1'b0;
    check("Outstanding", 32'(bus.Outstanding), 32'(m_inflight.size()));
    check("Full", 32'(bus.Full), 32'(m_inflight.size() == DEPTH));
    if (!lacc) begin
      check("LHTvalid_low", 32'(bus.LHTvalid), 32'd0);
      check("LHTresult_hold", 32'(bus.LHTresult), 32'(m_result));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(4);

    // First lookup of a fresh entry.
    cycle(1, 5, 0, 0);
    check("first_lookup", 32'(bus.LHTresult), 32'h000);
    check("first_outstanding", 32'(bus.Outstanding), 32'd1);

    // Train index 5 with ten taken, then three not-taken outcomes.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 1);
      cycle(1, 5, 0, 0);
    end
    check("train_ones", 32'(bus.LHTresult), 32'h3FF);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0);
      cycle(1, 5, 0, 0);
    end
    check("train_zeros", 32'(bus.LHTresult), 32'h3F8);
    cycle(0, 0, 1, 0);

    // Alternating outcomes on index 9.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 9, 0, 0);
      cycle(0, 0, 1, (i % 2) == 0);
    end
    cycle(1, 9, 0, 0);
    check("alternate", 32'(bus.LHTresult), 32'h00A);
    cycle(0, 0, 1, 0);

    // Fill the FIFO, reject a fifth lookup, then drain in order.
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0);
    check("full_set", 32'(bus.Full), 32'd1);
    cycle(1, 6, 0, 0);
    cycle(0, 0, 1, 1);
    check("full_clear", 32'(bus.Full), 32'd0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

    // Same-edge lookup and resolve on index 7 forwards the shifted history.
    cycle(1, 7, 0, 0);
    cycle(0, 0, 1, 1);
    cycle(1, 7, 0, 0);
    cycle(1, 7, 1, 1);
    check("bypass", 32'(bus.LHTresult), 32'h003);
    check("bypass_outstanding", 32'(bus.Outstanding), 32'd1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(1, 7, 0, 0);
    check("empty_resolve_ignored", 32'(bus.LHTresult), 32'h006);
    cycle(0, 0, 1, 0);

    // Reset with lookups in flight discards them and clears training.
    for (int i = 0; i < 3; i++) cycle(1, 5, 0, 0);
    check("pre_reset_outstanding", 32'(bus.Outstanding), 32'd3);
    do_reset(1);
    cycle(1, 5, 0, 0);
    check("post_reset_lookup", 32'(bus.LHTresult), 32'h000);

    // Random traffic over a small index set to exercise aliasing and wrap.
    for (int i = 0; i < 400; i++) begin
      bit lv;
      bit rv;
      lv = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0) && (m_inflight.size() > 0);
      cycle(lv, $urandom_range(0, 7), rv, $urandom_range(0, 1) == 1);
    end

    repeat (2) @(posedge clock);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
